// File: rtl/neuron_pkg.sv
// neuron_pkg: shared types and IEEE-754 constants for the time-multiplexed Izhikevich scheduler
package neuron_pkg;
    typedef enum logic [2:0] {RS, IB, CH, FS, TC, RZ, LTS} dyn_t;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
    } param_set;
    localparam logic [31:0] F_V0   = 32'hc2820000;
    localparam logic [31:0] F_U0   = 32'hc1500000;
    localparam logic [31:0] F_0P02 = 32'h3ca3d70a;
    localparam logic [31:0] F_0P05 = 32'h3d4ccccd;
    localparam logic [31:0] F_0P1  = 32'h3dcccccd;
    localparam logic [31:0] F_0P2  = 32'h3e4ccccd;
    localparam logic [31:0] F_0P25 = 32'h3e800000;
    localparam logic [31:0] F_0P26 = 32'h3e851eb8;
    localparam logic [31:0] F_M65  = 32'hc2820000;
    localparam logic [31:0] F_M55  = 32'hc25c0000;
    localparam logic [31:0] F_M50  = 32'hc2480000;
    localparam logic [31:0] F_2    = 32'h40000000;
    localparam logic [31:0] F_4    = 32'h40800000;
    localparam logic [31:0] F_8    = 32'h41000000;
endpackage

// File: rtl/neuron_param_rom.sv
// neuron_param_rom: combinational map from neuron dynamic type to Izhikevich a/b/c/d
module neuron_param_rom
    import neuron_pkg::*;
(
    input  dyn_t     ntype,
    output param_set p
);
    always_comb begin
        p = '{F_0P02, F_0P2, F_M65, F_8};
        case (ntype)
            IB:      p = '{F_0P02, F_0P2, F_M55, F_4};
            CH:      p = '{F_0P02, F_0P2, F_M50, F_2};
            FS:      p = '{F_0P1, F_0P2, F_M65, F_2};
            TC:      p = '{F_0P02, F_0P25, F_M65, F_0P05};
            RZ:      p = '{F_0P1, F_0P26, F_M65, F_2};
            LTS:     p = '{F_0P02, F_0P25, F_M65, F_2};
            default: ;
        endcase
    end
endmodule

// File: rtl/neuron_scheduler.sv
// neuron_scheduler: issues every neuron once per timestep to a shared datapath and retires results
// NEURON_SPIKE_COUNT_EN adds per-neuron saturating spike counters read through cnt_idx/cnt_out.
module neuron_scheduler
    import neuron_pkg::*;
#(
    parameter int N_NEURONS = 16,
    parameter int DP_LAT = 4,
    localparam int IW = $clog2(N_NEURONS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic [2:0]    cfg_type,
    input  logic [31:0]   cfg_iext,
    output logic          cfg_drop,
    output logic          dp_valid,
    output logic [IW-1:0] dp_tag,
    output logic [31:0]   dp_v,
    output logic [31:0]   dp_u,
    output logic [31:0]   dp_i,
    output logic [31:0]   dp_a,
    output logic [31:0]   dp_b,
    output logic [31:0]   dp_c,
    output logic [31:0]   dp_d,
    input  logic          dp_rvalid,
    input  logic [IW-1:0] dp_rtag,
    input  logic [31:0]   dp_vn,
    input  logic [31:0]   dp_un,
    input  logic          dp_spike,
    output logic          spike_valid,
    output logic [IW-1:0] spike_idx
`ifdef NEURON_SPIKE_COUNT_EN
    ,
    input  logic [IW-1:0] cnt_idx,
    output logic [15:0]   cnt_out
`endif
);
    localparam int OW = $clog2((DP_LAT > N_NEURONS ? DP_LAT : N_NEURONS) + 1);
    state_t        state, state_n;
    logic [IW-1:0] iss_idx;
    logic [OW-1:0] outst, outst_n;
    logic          issue, ret, last;
    dyn_t          type_mem [N_NEURONS];
    logic [31:0]   iext_mem [N_NEURONS];
    logic [31:0]   v_mem [N_NEURONS];
    logic [31:0]   u_mem [N_NEURONS];
    param_set      ps;
    assign issue   = state == ISSUE;
    assign ret     = dp_rvalid && (state == ISSUE || state == DRAIN);
    assign last    = iss_idx == IW'(N_NEURONS - 1);
    assign outst_n = outst + OW'(issue) - OW'(ret);
    // Drain ends on the cycle the final return retires, so done lands N+DP_LAT+1 after start.
    always_comb begin
        state_n = state == IDLE  ? (start ? ISSUE : IDLE) :
                  state == ISSUE ? (last ? DRAIN : ISSUE) :
                  state == DRAIN ? (outst_n == '0 ? DONE : DRAIN) : IDLE;
        busy    = state == ISSUE || state == DRAIN;
        done    = state == DONE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            iss_idx     <= '0;
            outst       <= '0;
            cfg_drop    <= 1'b0;
            spike_valid <= 1'b0;
            spike_idx   <= '0;
        end else begin
            state       <= state_n;
            iss_idx     <= issue ? iss_idx + 1'b1 : iss_idx;
            outst       <= outst_n;
            cfg_drop    <= cfg_we && busy;
            spike_valid <= ret && dp_spike;
            if (ret && dp_spike) spike_idx <= dp_rtag;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_NEURONS; k++) begin
                type_mem[k] <= RS;
                iext_mem[k] <= '0;
                v_mem[k]    <= F_V0;
                u_mem[k]    <= F_U0;
            end
        end else begin
            if (ret) begin
                v_mem[dp_rtag] <= dp_vn;
                u_mem[dp_rtag] <= dp_un;
            end
            if (cfg_we && state == IDLE) begin
                type_mem[cfg_idx] <= cfg_type == 3'd7 ? RS : dyn_t'(cfg_type);
                iext_mem[cfg_idx] <= cfg_iext;
            end
        end
    end
    neuron_param_rom u_rom (.ntype(type_mem[iss_idx]), .p(ps));
    // Issue fields are gated so every datapath output reads zero outside ISSUE.
    always_comb begin
        dp_valid = issue;
        dp_tag   = issue ? iss_idx : '0;
        dp_v     = issue ? v_mem[iss_idx] : '0;
        dp_u     = issue ? u_mem[iss_idx] : '0;
        dp_i     = issue ? iext_mem[iss_idx] : '0;
        dp_a     = issue ? ps.a : '0;
        dp_b     = issue ? ps.b : '0;
        dp_c     = issue ? ps.c : '0;
        dp_d     = issue ? ps.d : '0;
    end
`ifdef NEURON_SPIKE_COUNT_EN
    logic [15:0] spk_cnt [N_NEURONS];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_NEURONS; k++) spk_cnt[k] <= '0;
        end else if (ret && dp_spike && spk_cnt[dp_rtag] != 16'hffff) begin
            spk_cnt[dp_rtag] <= spk_cnt[dp_rtag] + 1'b1;
        end
    end
    assign cnt_out = spk_cnt[cnt_idx];
`endif
endmodule

// File: tb/tb_neuron_scheduler.sv
// tb_neuron_scheduler: randomized bench with a timestep-level reference model and a fixed-latency datapath model
module tb_neuron_scheduler;
    localparam int N = 16;
    localparam int L = 4;
    localparam int IW = 4;
    logic          clk = 0, rst = 1, start = 0, cfg_we = 0;
    logic [IW-1:0] cfg_idx = '0;
    logic [2:0]    cfg_type = '0;
    logic [31:0]   cfg_iext = '0;
    logic          busy, done, cfg_drop, dp_valid, spike_valid;
    logic [IW-1:0] dp_tag, spike_idx;
    logic [31:0]   dp_v, dp_u, dp_i, dp_a, dp_b, dp_c, dp_d;
    logic          dp_rvalid = 0, dp_spike = 0;
    logic [IW-1:0] dp_rtag = '0;
    logic [31:0]   dp_vn = '0, dp_un = '0;
`ifdef NEURON_SPIKE_COUNT_EN
    logic [IW-1:0] cnt_idx = '0;
    logic [15:0]   cnt_out;
    int            m_cnt [N];
`endif
    always #5 clk = ~clk;
    neuron_scheduler #(.N_NEURONS(N), .DP_LAT(L)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_type(cfg_type), .cfg_iext(cfg_iext), .cfg_drop(cfg_drop),
        .dp_valid(dp_valid), .dp_tag(dp_tag), .dp_v(dp_v), .dp_u(dp_u), .dp_i(dp_i),
        .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_d(dp_d),
        .dp_rvalid(dp_rvalid), .dp_rtag(dp_rtag), .dp_vn(dp_vn), .dp_un(dp_un), .dp_spike(dp_spike),
        .spike_valid(spike_valid), .spike_idx(spike_idx)
`ifdef NEURON_SPIKE_COUNT_EN
        , .cnt_idx(cnt_idx), .cnt_out(cnt_out)
`endif
    );
    // Izhikevich table by type code; code 7 behaves as RS.
    logic [31:0] pa [8] = '{32'h3ca3d70a, 32'h3ca3d70a, 32'h3ca3d70a, 32'h3dcccccd,
                            32'h3ca3d70a, 32'h3dcccccd, 32'h3ca3d70a, 32'h3ca3d70a};
    logic [31:0] pb [8] = '{32'h3e4ccccd, 32'h3e4ccccd, 32'h3e4ccccd, 32'h3e4ccccd,
                            32'h3e800000, 32'h3e851eb8, 32'h3e800000, 32'h3e4ccccd};
    logic [31:0] pc [8] = '{32'hc2820000, 32'hc25c0000, 32'hc2480000, 32'hc2820000,
                            32'hc2820000, 32'hc2820000, 32'hc2820000, 32'hc2820000};
    logic [31:0] pd [8] = '{32'h41000000, 32'h40800000, 32'h40000000, 32'h40000000,
                            32'h3d4ccccd, 32'h40000000, 32'h40000000, 32'h41000000};
    typedef struct {
        int          due;
        int          tag;
        logic [31:0] vn;
        logic [31:0] un;
        bit          spk;
    } ret_t;
    ret_t        q [$];
    int          cyc = 0, n_cmp = 0, n_err = 0, s0 = 0, e_sidx = 0;
    bit          active = 0, e_spk = 0, e_drop = 0;
    logic [2:0]  m_type [N];
    logic [31:0] m_iext [N], m_v [N], m_u [N];
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask
    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_type[i] = 3'd0;
            m_iext[i] = '0;
            m_v[i]    = 32'hc2820000;
            m_u[i]    = 32'hc1500000;
`ifdef NEURON_SPIKE_COUNT_EN
            m_cnt[i]  = 0;
`endif
        end
        active = 0;
        e_spk  = 0;
        e_drop = 0;
    endtask
    // One cycle: check what the DUT shows now, then drive this cycle's inputs and advance the model.
    task automatic step(input bit st = 0, input bit we = 0, input int idx = 0, input int typ = 0,
                        input logic [31:0] ie = '0, input bit r = 0);
        int   rel, tag;
        bit   ebusy, edone, evalid, idle, nspk;
        ret_t e;
        @(negedge clk);
        cyc++;
        rel    = cyc - s0;
        ebusy  = active && rel >= 1 && rel <= N + L;
        edone  = active && rel == N + L + 1;
        evalid = active && rel >= 1 && rel <= N;
        idle   = !active || rel >= N + L + 2;
        chk("busy", 32'(busy), 32'(ebusy));
        chk("done", 32'(done), 32'(edone));
        chk("dp_valid", 32'(dp_valid), 32'(evalid));
        chk("spike_valid", 32'(spike_valid), 32'(e_spk));
        chk("cfg_drop", 32'(cfg_drop), 32'(e_drop));
        if (e_spk) chk("spike_idx", 32'(spike_idx), 32'(e_sidx));
`ifdef NEURON_SPIKE_COUNT_EN
        chk("cnt_out", 32'(cnt_out), 32'(m_cnt[cnt_idx]));
        cnt_idx = IW'($urandom_range(0, N - 1));
`endif
        if (evalid) begin
            tag = rel - 1;
            chk("dp_tag", 32'(dp_tag), 32'(tag));
            chk("dp_v", dp_v, m_v[tag]);
            chk("dp_u", dp_u, m_u[tag]);
            chk("dp_i", dp_i, m_iext[tag]);
            chk("dp_a", dp_a, pa[m_type[tag]]);
            chk("dp_b", dp_b, pb[m_type[tag]]);
            chk("dp_c", dp_c, pc[m_type[tag]]);
            chk("dp_d", dp_d, pd[m_type[tag]]);
            e.due = cyc + L;
            e.tag = tag;
            e.vn  = $urandom;
            e.un  = $urandom;
            e.spk = tag == 5 || $urandom_range(0, 3) == 0;
            q.push_back(e);
        end
        nspk = 0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e         = q.pop_front();
            dp_rvalid = 1;
            dp_rtag   = IW'(e.tag);
            dp_vn     = e.vn;
            dp_un     = e.un;
            dp_spike  = e.spk;
            if (ebusy) begin
                m_v[e.tag] = e.vn;
                m_u[e.tag] = e.un;
                if (e.spk) begin
                    nspk   = 1;
                    e_sidx = e.tag;
`ifdef NEURON_SPIKE_COUNT_EN
                    if (m_cnt[e.tag] < 65535) m_cnt[e.tag]++;
`endif
                end
            end
        end else begin
            dp_rvalid = 0;
            dp_rtag   = IW'($urandom);
            dp_vn     = $urandom;
            dp_un     = $urandom;
            dp_spike  = 1'($urandom);
        end
        e_spk  = nspk;
        e_drop = we && ebusy;
        if (we && idle) begin
            m_type[idx] = 3'(typ);
            m_iext[idx] = ie;
        end
        if (st && idle) begin
            active = 1;
            s0     = cyc;
        end
        start    = st;
        cfg_we   = we;
        cfg_idx  = IW'(idx);
        cfg_type = 3'(typ);
        cfg_iext = ie;
        rst      = r;
        if (r) model_reset();
    endtask
    initial begin
        model_reset();
        repeat (3) step(.r(1));
        chk("rst_dp_v", dp_v, '0);
        chk("rst_dp_tag", 32'(dp_tag), '0);
        chk("rst_dp_a", dp_a, '0);
        chk("rst_dp_i", dp_i, '0);
        chk("rst_spike_idx", 32'(spike_idx), '0);
        step();
        repeat (6) step(.we(1), .idx($urandom_range(0, N - 1)), .typ($urandom_range(0, 7)), .ie($urandom));
        step(.we(1), .idx(3), .typ(2), .ie(32'h40a00000));
        step(.we(1), .idx(9), .typ(7), .ie(32'h41200000));
        step(.st(1));
        repeat (N + L + 3) step();
        // Config write during ISSUE is dropped; a second start during DRAIN is ignored.
        step(.st(1));
        repeat (3) step();
        step(.we(1), .idx(3), .typ(0), .ie(32'h0));
        repeat (14) step();
        step(.st(1));
        repeat (6) step();
        step(.st(1));
        repeat (N + L + 3) step();
        // Reset eight cycles into a timestep; stale returns then land while idle.
        step(.st(1));
        repeat (7) step();
        step(.r(1));
        step(.r(1));
        chk("abort_busy", 32'(busy), '0);
        repeat (6) step();
        step(.st(1));
        repeat (N + L + 3) step();
        repeat (4) begin
            repeat (3) step(.we(1), .idx($urandom_range(0, N - 1)), .typ($urandom_range(0, 7)), .ie($urandom));
            step(.st(1));
            repeat (N + L + 2 + $urandom_range(0, 3)) step(.st($urandom_range(0, 7) == 0));
        end
        repeat (N + L + 4) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
